// File: rtl/up_ramcfg_initctl_if.sv
// rtl/up_ramcfg_initctl_if.sv - single-access up-port bus (enable, address, strobes, data, ready)
interface up_ramcfg_initctl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          en;
    logic [AW-1:0] a;
    logic          ws;
    logic          rs;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rdy;

    modport master (output en, a, ws, rs, wdata, input  rdata, rdy);
    modport slave  (input  en, a, ws, rs, wdata, output rdata, rdy);
endinterface

// File: rtl/up_ramcfg_initctl.sv
// rtl/up_ramcfg_initctl.sv - config RAM up-port sequencer: init sweep plus forwarded CPU accesses
module up_ramcfg_initctl #(
    parameter int                 G_ADDR    = 10,
    parameter int                 G_WIDTH   = 32,
    parameter logic [G_WIDTH-1:0] G_INITVAL = '0,
    parameter int                 G_TOUT    = 255,
    parameter logic [G_WIDTH-1:0] G_ERRVAL  = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_start_i,
    output logic                init_busy_o,
    output logic                init_done_o,
    output logic                tout_err_o,
    up_ramcfg_initctl_if.slave  cpu,
    up_ramcfg_initctl_if.master ram
);

    typedef enum logic [1:0] {S_INIT, S_IWAIT, S_IDLE, S_CPU} state_t;

    localparam logic [G_ADDR-1:0] LAST_ADDR = '1;
    localparam logic [7:0]        TOUT_CNT  = G_TOUT[7:0];

    state_t               state_q, state_d;
    logic [G_ADDR-1:0]    cnt_q, cnt_d;
    logic [7:0]           tcnt_q, tcnt_d;
    logic                 init_busy_q, init_busy_d;
    logic                 init_done_q, init_done_d;
    logic                 tout_err_q, tout_err_d;
    logic                 init_req_q, init_req_d;
    logic                 uprdy_q, uprdy_d;
    logic [G_WIDTH-1:0]   updo_q, updo_d;
    logic                 mupen_q, mupen_d;
    logic                 mupws_q, mupws_d;
    logic                 muprs_q, muprs_d;
    logic [G_ADDR-1:0]    mupa_q, mupa_d;
    logic [G_WIDTH-1:0]   mupdi_q, mupdi_d;
    logic                 pend_q, pend_d;
    logic                 pwr_q, pwr_d;
    logic [G_ADDR-1:0]    pa_q, pa_d;
    logic [G_WIDTH-1:0]   pd_q, pd_d;
    logic                 timeout;

    assign timeout = (tcnt_q == TOUT_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        init_busy_d = init_busy_q;
        init_done_d = 1'b0;
        tout_err_d  = 1'b0;
        init_req_d  = init_req_q;
        uprdy_d     = 1'b0;
        updo_d      = updo_q;
        mupen_d     = mupen_q;
        mupws_d     = 1'b0;
        muprs_d     = 1'b0;
        mupa_d      = mupa_q;
        mupdi_d     = mupdi_q;
        pend_d      = pend_q;
        pwr_d       = pwr_q;
        pa_d        = pa_q;
        pd_d        = pd_q;

        if (cpu.en && (cpu.ws || cpu.rs) && !pend_q) begin
            pend_d = 1'b1;
            pwr_d  = cpu.ws;
            pa_d   = cpu.a;
            pd_d   = cpu.wdata;
        end else if (!cpu.en) begin
            pend_d = 1'b0;
        end

        case (state_q)
            S_INIT: begin
                mupen_d = 1'b1;
                mupws_d = 1'b1;
                mupa_d  = cnt_q;
                mupdi_d = G_INITVAL;
                tcnt_d  = '0;
                state_d = S_IWAIT;
            end
            // A restart request during a sweep is dropped: the running sweep already covers it.
            S_IWAIT: begin
                if (ram.rdy || timeout) begin
                    mupen_d    = 1'b0;
                    tout_err_d = !ram.rdy;
                    if (cnt_q == LAST_ADDR) begin
                        init_done_d = 1'b1;
                        init_busy_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + G_ADDR'(1);
                        state_d = S_INIT;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (init_start_i || init_req_q) begin
                    init_req_d  = 1'b0;
                    init_busy_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_INIT;
                end else if (pend_q && cpu.en) begin
                    mupen_d = 1'b1;
                    mupws_d = pwr_q;
                    muprs_d = !pwr_q;
                    mupa_d  = pa_q;
                    mupdi_d = pd_q;
                    tcnt_d  = '0;
                    state_d = S_CPU;
                end
            end
            S_CPU: begin
                if (init_start_i) begin
                    init_req_d = 1'b1;
                end
                if (ram.rdy) begin
                    mupen_d = 1'b0;
                    uprdy_d = 1'b1;
                    if (!pwr_q) begin
                        updo_d = ram.rdata;
                    end
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    mupen_d    = 1'b0;
                    uprdy_d    = 1'b1;
                    updo_d     = G_ERRVAL;
                    tout_err_d = 1'b1;
                    pend_d     = 1'b0;
                    state_d    = S_IDLE;
                end else if (!cpu.en) begin
                    mupen_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            init_busy_q <= 1'b1;
            init_done_q <= 1'b0;
            tout_err_q  <= 1'b0;
            init_req_q  <= 1'b0;
            uprdy_q     <= 1'b0;
            updo_q      <= '0;
            mupen_q     <= 1'b0;
            mupws_q     <= 1'b0;
            muprs_q     <= 1'b0;
            mupa_q      <= '0;
            mupdi_q     <= '0;
            pend_q      <= 1'b0;
            pwr_q       <= 1'b0;
            pa_q        <= '0;
            pd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            tout_err_q  <= tout_err_d;
            init_req_q  <= init_req_d;
            uprdy_q     <= uprdy_d;
            updo_q      <= updo_d;
            mupen_q     <= mupen_d;
            mupws_q     <= mupws_d;
            muprs_q     <= muprs_d;
            mupa_q      <= mupa_d;
            mupdi_q     <= mupdi_d;
            pend_q      <= pend_d;
            pwr_q       <= pwr_d;
            pa_q        <= pa_d;
            pd_q        <= pd_d;
        end
    end

    assign init_busy_o = init_busy_q;
    assign init_done_o = init_done_q;
    assign tout_err_o  = tout_err_q;
    assign cpu.rdy     = uprdy_q;
    assign cpu.rdata   = updo_q;
    assign ram.en      = mupen_q;
    assign ram.ws      = mupws_q;
    assign ram.rs      = muprs_q;
    assign ram.a       = mupa_q;
    assign ram.wdata   = mupdi_q;

endmodule

// File: tb/tb_up_ramcfg_initctl.sv
// tb/tb_up_ramcfg_initctl.sv - directed and random bench for up_ramcfg_initctl with a RAM model
module tb_up_ramcfg_initctl;
    localparam int          AW    = 4;
    localparam int          DW    = 32;
    localparam int          TOUT  = 8;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] INITV = 32'h0;
    localparam logic [31:0] ERRV  = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_start = 1'b0;
    logic init_busy, init_done, tout_err;

    always #5 clk = ~clk;

    up_ramcfg_initctl_if #(.AW(AW), .DW(DW)) cpu_if ();
    up_ramcfg_initctl_if #(.AW(AW), .DW(DW)) ram_if ();

    up_ramcfg_initctl #(
        .G_ADDR(AW), .G_WIDTH(DW), .G_INITVAL(INITV), .G_TOUT(TOUT), .G_ERRVAL(ERRV)
    ) dut (
        .clk(clk), .rst(rst), .init_start_i(init_start),
        .init_busy_o(init_busy), .init_done_o(init_done), .tout_err_o(tout_err),
        .cpu(cpu_if), .ram(ram_if)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [WORDS];
    bit          ram_dead = 1'b0;
    int          wlog_a [$];
    logic [31:0] wlog_d [$];

    // RAM model: answers a strobe with ready in the same cycle the strobe is visible
    always @(negedge clk) begin
        ram_if.rdy = 1'b0;
        if (!rst && ram_if.en && !ram_dead && (ram_if.ws || ram_if.rs)) begin
            if (ram_if.ws) begin
                ram_mem[ram_if.a] = ram_if.wdata;
                wlog_a.push_back(int'(ram_if.a));
                wlog_d.push_back(ram_if.wdata);
            end else begin
                ram_if.rdata = ram_mem[ram_if.a];
            end
            ram_if.rdy = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cpu_op(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input int istart_at, output logic [31:0] rd, output int lat,
                          output bit got, output bit terr, output bit men);
        cpu_if.en = 1'b1; cpu_if.ws = wr; cpu_if.rs = !wr; cpu_if.a = a; cpu_if.wdata = d;
        lat = 0; got = 1'b0; terr = 1'b0; rd = '0; men = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            lat++;
            if (i == 0) begin cpu_if.ws = 1'b0; cpu_if.rs = 1'b0; end
            init_start = (i == istart_at);
            if (cpu_if.rdy === 1'b1) begin
                got = 1'b1; rd = cpu_if.rdata; terr = tout_err; men = ram_if.en;
                break;
            end
        end
        init_start = 1'b0;
        cpu_if.en = 1'b0;
        tick();
    endtask

    logic [31:0] exp_mem [WORDS];
    logic [31:0] exp_updo;
    logic [31:0] rd;
    int          lat, k;
    bit          got, terr, men, wr, seen_done, stale;
    logic [AW-1:0] a;
    logic [31:0] d;

    initial begin
        cpu_if.en = 1'b0; cpu_if.ws = 1'b0; cpu_if.rs = 1'b0; cpu_if.a = '0; cpu_if.wdata = '0;
        ram_if.rdy = 1'b0; ram_if.rdata = '0;
        foreach (ram_mem[i]) ram_mem[i] = $urandom;
        foreach (exp_mem[i]) exp_mem[i] = INITV;
        exp_updo = '0;

        // reset state
        repeat (3) tick();
        chk("rst_busy", init_busy, 1);
        chk("rst_done", init_done, 0);
        chk("rst_terr", tout_err, 0);
        chk("rst_uprdy", cpu_if.rdy, 0);
        chk("rst_updo", cpu_if.rdata, 0);
        chk("rst_mupen", ram_if.en, 0);
        chk("rst_mupws", ram_if.ws, 0);

        // automatic sweep: one word per two cycles
        rst = 1'b0;
        k = 0;
        while (init_done !== 1'b1 && k < 200) begin
            tick(); k++;
            if (k == 10) chk("sweep_busy_mid", init_busy, 1);
        end
        chk("sweep_done_seen", init_done, 1);
        chk("sweep_cycles", k, 2 * WORDS);
        chk("sweep_busy_end", init_busy, 0);
        chk("sweep_nwrites", wlog_a.size(), WORDS);
        if (wlog_a.size() == WORDS) begin
            for (int i = 0; i < WORDS; i++) begin
                chk("sweep_addr", wlog_a[i], i);
                chk("sweep_data", wlog_d[i], INITV);
            end
        end
        tick();
        chk("done_pulse", init_done, 0);

        // directed write/read then random traffic against the array model
        cpu_op(1'b1, 4'd5, 32'h12345678, -1, rd, lat, got, terr, men);
        exp_mem[5] = 32'h12345678;
        chk("wr5_rdy", got, 1);
        chk("wr5_lat", lat, 3);
        chk("wr5_updo_kept", rd, exp_updo);
        cpu_op(1'b0, 4'd5, 32'h0, -1, rd, lat, got, terr, men);
        exp_updo = exp_mem[5];
        chk("rd5_rdy", got, 1);
        chk("rd5_lat", lat, 3);
        chk("rd5_data", rd, 32'h12345678);
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, WORDS - 1));
            d  = $urandom;
            cpu_op(wr, a, d, -1, rd, lat, got, terr, men);
            if (!wr) exp_updo = exp_mem[a];
            else     exp_mem[a] = d;
            chk("rnd_rdy", got, 1);
            chk("rnd_lat", lat, 3);
            chk("rnd_updo", rd, exp_updo);
            chk("rnd_terr", terr, 0);
        end
        cpu_op(1'b1, 4'd3, 32'hA5A55A5A, -1, rd, lat, got, terr, men);
        exp_mem[3] = 32'hA5A55A5A;
        chk("wr3_rdy", got, 1);

        // re-init, then a read arriving mid-sweep waits for the sweep to finish
        init_start = 1'b1; tick(); init_start = 1'b0;
        foreach (exp_mem[i]) exp_mem[i] = INITV;
        repeat (6) tick();
        chk("reinit_busy", init_busy, 1);
        cpu_if.en = 1'b1; cpu_if.rs = 1'b1; cpu_if.a = 4'd3;
        tick(); cpu_if.rs = 1'b0;
        seen_done = 1'b0; got = 1'b0; k = 0;
        while (k < 200) begin
            tick(); k++;
            if (init_done === 1'b1) seen_done = 1'b1;
            if (cpu_if.rdy === 1'b1) begin got = 1'b1; break; end
        end
        chk("held_rdy", got, 1);
        chk("held_after_done", seen_done, 1);
        chk("held_data", cpu_if.rdata, exp_mem[3]);
        chk("held_busy", init_busy, 0);
        exp_updo = exp_mem[3];
        cpu_if.en = 1'b0; tick();

        // RAM never answers: timeout abort
        ram_dead = 1'b1;
        cpu_op(1'b0, AW'($urandom_range(0, WORDS - 1)), 32'h0, -1, rd, lat, got, terr, men);
        chk("tout_rdy", got, 1);
        chk("tout_lat", lat, 2 + TOUT + 1);
        chk("tout_err", terr, 1);
        chk("tout_updo", rd, ERRV);
        chk("tout_mupen", men, 0);

        // init_start during a CPU access is deferred until the access completes
        wlog_a.delete(); wlog_d.delete();
        cpu_op(1'b0, 4'd1, 32'h0, 3, rd, lat, got, terr, men);
        ram_dead = 1'b0;
        chk("defer_rdy", got, 1);
        chk("defer_lat", lat, 2 + TOUT + 1);
        chk("defer_terr", terr, 1);
        chk("defer_no_write_yet", wlog_a.size(), 0);
        chk("defer_busy", init_busy, 1);

        // pending read mid-sweep, then reset at sweep address 7
        k = 0;
        while (!(ram_if.en && ram_if.ws && ram_if.a == 4'd5) && k < 100) begin tick(); k++; end
        chk("sweep5_seen", k < 100, 1);
        chk("defer_first_addr", wlog_a.size() > 0 ? wlog_a[0] : -1, 0);
        cpu_if.en = 1'b1; cpu_if.rs = 1'b1; cpu_if.a = 4'd9;
        tick(); cpu_if.rs = 1'b0;
        k = 0;
        while (!(ram_if.en && ram_if.ws && ram_if.a == 4'd7) && k < 100) begin tick(); k++; end
        chk("sweep7_seen", k < 100, 1);
        rst = 1'b1;
        tick();
        cpu_if.en = 1'b0;
        tick();
        chk("rst2_mupen", ram_if.en, 0);
        chk("rst2_uprdy", cpu_if.rdy, 0);
        chk("rst2_busy", init_busy, 1);
        chk("rst2_updo", cpu_if.rdata, 0);
        wlog_a.delete(); wlog_d.delete();
        rst = 1'b0;
        k = 0; stale = 1'b0;
        while (init_done !== 1'b1 && k < 200) begin
            tick(); k++;
            if (cpu_if.rdy === 1'b1) stale = 1'b1;
        end
        chk("rst2_cycles", k, 2 * WORDS);
        chk("rst2_nwrites", wlog_a.size(), WORDS);
        chk("rst2_first_addr", wlog_a.size() > 0 ? wlog_a[0] : -1, 0);
        repeat (5) begin
            tick();
            if (cpu_if.rdy === 1'b1) stale = 1'b1;
        end
        chk("rst2_no_stale_uprdy", stale, 0);
        cpu_op(1'b0, 4'd5, 32'h0, -1, rd, lat, got, terr, men);
        chk("final_rdy", got, 1);
        chk("final_data", rd, exp_mem[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
